// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester and UART TX FIFO signal bundle for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    logic                         enable;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_wren;
    logic [DATA_BITS-1:0]         fifo_data;
    logic                         start_tx;
    logic [NUM_REQ-1:0]           grant;
    logic                         busy;

    modport master (
        input  enable, req_valid, req_last, req_data, fifo_full, fifo_empty,
        output req_ready, fifo_wren, fifo_data, start_tx, grant, busy
    );

    modport slave (
        output enable, req_valid, req_last, req_data, fifo_full, fifo_empty,
        input  req_ready, fifo_wren, fifo_data, start_tx, grant, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter moving NUM_REQ byte streams into one UART
//               TX FIFO; stall timeout enabled by macro UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    uart_tx_arbiter_if.master bus
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic              timeout_flag
`endif
);
    localparam int c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARB     = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_gidx;
    logic [c_IDX_W-1:0]   w_sel_idx;
    logic [c_IDX_W-1:0]   w_cand;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_snap;
    logic [NUM_REQ-1:0]   w_req_ready;
    logic [c_BURST_W-1:0] r_burst;
    logic                 r_busy;
    logic                 r_start_tx;
    logic                 w_sel_hit;
    logic                 w_handshake;
    logic                 w_last;
    logic                 w_burst_done;
    logic                 w_timeout_hit;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT < 1) begin : g_param_check
            $error("uart_tx_arbiter: parameter out of range");
        end
    endgenerate

    // Arbitration works on the request vector captured in IDLE, so an owner
    // whose valid drops during ARB is still granted.
    always_comb begin
        w_sel_hit = 1'b0;
        w_sel_idx = r_ptr;
        w_cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = c_IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_sel_hit && r_snap[w_cand]) begin
                w_sel_hit = 1'b1;
                w_sel_idx = w_cand;
            end
        end
    end

    assign w_req_ready  = (r_state == S_XFER && !bus.fifo_full) ? r_grant : '0;
    assign w_handshake  = |(bus.req_valid & w_req_ready);
    assign w_last       = bus.req_last[r_gidx];
    assign w_burst_done = (r_burst == c_BURST_W'(MAX_BURST - 1));

    assign bus.req_ready = w_req_ready;
    assign bus.fifo_wren = w_handshake;
    assign bus.fifo_data = w_handshake ? bus.req_data[r_gidx*DATA_BITS +: DATA_BITS] : '0;
    assign bus.start_tx  = r_start_tx;
    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);

    logic [c_TO_W-1:0] r_idle_cnt;
    logic              r_timeout_flag;

    assign w_timeout_hit = (r_state == S_XFER) && !bus.req_valid[r_gidx] &&
                           (r_idle_cnt == c_TO_W'(TIMEOUT - 1));
    assign timeout_flag  = r_timeout_flag;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt     <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (r_state == S_ARB || w_handshake) begin
                r_idle_cnt <= '0;
            end else if (r_state == S_XFER && !bus.req_valid[r_gidx]) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_timeout_hit) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.enable && |bus.req_valid) begin
                    w_next_state = S_ARB;
                end
            end
            S_ARB: begin
                w_next_state = w_sel_hit ? S_XFER : S_IDLE;
            end
            S_XFER: begin
                if ((w_handshake && (w_last || w_burst_done)) || w_timeout_hit) begin
                    w_next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= c_IDX_W'(NUM_REQ - 1);
            r_gidx     <= '0;
            r_grant    <= '0;
            r_snap     <= '0;
            r_burst    <= '0;
            r_busy     <= 1'b0;
            r_start_tx <= 1'b0;
        end else begin
            r_start_tx <= bus.enable & ~bus.fifo_empty;
            case (r_state)
                S_IDLE: begin
                    r_snap <= bus.req_valid;
                end
                S_ARB: begin
                    r_gidx  <= w_sel_idx;
                    r_grant <= w_sel_hit ? (NUM_REQ'(1) << w_sel_idx) : '0;
                    r_busy  <= w_sel_hit;
                    r_burst <= '0;
                end
                S_XFER: begin
                    if (w_handshake) begin
                        r_burst <= r_burst + 1'b1;
                    end
                end
                S_RELEASE: begin
                    // Releasing owner becomes lowest priority for the next round.
                    r_ptr   <= r_gidx;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
